// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    HOLD
  } div_state_t;

endpackage

// File: rtl/divider_control.sv
// Sequencer for the restoring divider: operator handshake, step counter and
// result-hold state. State is exported on state_o for observation.
module divider_control
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_i,
  input  logic       clear_a_load_b_i,
  output logic       load_b_o,
  output logic       clear_a_o,
  output logic       load_d_o,
  output logic       step_o,
  output logic       done_o,
  output div_state_t state_o
);

  div_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Load has priority over run while idle; a held run then starts next cycle.
  // COMPUTE spends one extra cycle with count==WIDTH before entering HOLD.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_b_o  = 1'b0;
    clear_a_o = 1'b0;
    load_d_o  = 1'b0;
    step_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_a_load_b_i) begin
          load_b_o  = 1'b1;
          clear_a_o = 1'b1;
        end else if (run_i) begin
          load_d_o = 1'b1;
          count_d  = '0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        if (count_q == CW'(WIDTH)) begin
          state_d = HOLD;
        end else begin
          step_o  = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      HOLD: begin
        done_o = 1'b1;
        if (!run_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/restoring_divider.sv
// Unsigned restoring divider: quotient builds up in B, remainder in A,
// one quotient bit per clock.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clearA_loadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             done,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
  logic [WIDTH:0]   a_shift, diff;
  logic             load_b, clear_a, load_d, step;
  div_state_t       state;

  divider_control #(.WIDTH(WIDTH)) u_control (
    .clk              (clk),
    .reset            (reset),
    .run_i            (run),
    .clear_a_load_b_i (clearA_loadB),
    .load_b_o         (load_b),
    .clear_a_o        (clear_a),
    .load_d_o         (load_d),
    .step_o           (step),
    .done_o           (done),
    .state_o          (state)
  );

  // A stays below D, so the shifted partial remainder fits in WIDTH+1 bits.
  assign a_shift = {a_q, b_q[WIDTH-1]};
  assign diff    = a_shift - {1'b0, d_q};

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    d_d = d_q;
    if (load_b)  b_d = S;
    if (clear_a) a_d = '0;
    if (load_d)  d_d = S;
    if (step) begin
      a_d = diff[WIDTH] ? a_shift[WIDTH-1:0] : diff[WIDTH-1:0];
      b_d = {b_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      d_q <= d_d;
    end
  end

  assign Aval        = a_q;
  assign Bval        = b_q;
  assign div_by_zero = (state == HOLD) && (d_q == '0);

endmodule

// File: tb/tb_restoring_divider.sv
// Randomized and directed bench for restoring_divider with a result scoreboard.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, run, clearA_loadB;
  logic [W-1:0] S, Aval, Bval;
  logic         done, div_by_zero;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_exp;
  logic         done_prev = 1'b0;
  logic [W-1:0] model_dividend = '0;
  int           checks = 0;
  int           errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .clearA_loadB (clearA_loadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .done         (done),
    .div_by_zero  (div_by_zero)
  );

  // ---------------- reference model ----------------
  // Result packed as {div_by_zero, remainder, quotient}.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    if (dvs == '0) return {1'b1, dvd, {W{1'b1}}};
    return {1'b0, W'(dvd % dvs), W'(dvd / dvs)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%0h expected none", {div_by_zero, Aval, Bval});
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {15'd0, div_by_zero, Aval, Bval}, {15'd0, mon_exp});
      end
    end
    done_prev = done;
  end

  // ---------------- driver tasks ----------------
  task automatic load(input logic [W-1:0] v);
    clearA_loadB = 1'b1;
    run          = 1'b0;
    S            = v;
    @(posedge clk); #1;
    clearA_loadB   = 1'b0;
    model_dividend = v;
    check("load_B", {24'd0, Bval}, {24'd0, v});
    check("load_A", {24'd0, Aval}, 32'd0);
  endtask

  // Called just after the edge at which run was sampled in IDLE.
  task automatic finish_div(input int hold, input bit disturb);
    int k;
    logic [2*W:0] snap;
    for (k = 1; k <= 20; k++) begin
      if (disturb && k == 3) begin
        clearA_loadB = 1'b1;
        S            = 8'h77;
      end
      if (disturb && k == 4) begin
        clearA_loadB = 1'b0;
        S            = ~S;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    check("latency", k, W + 1);
    snap = {div_by_zero, Aval, Bval};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold", {14'd0, done, div_by_zero, Aval, Bval}, {14'd0, 1'b1, snap});
    end
    run = 1'b0;
    @(posedge clk); #1;
    check("release", {30'd0, done, div_by_zero}, 32'd0);
  endtask

  task automatic run_div(input logic [W-1:0] dvs, input int hold, input bit disturb);
    run = 1'b1;
    S   = dvs;
    exp_q.push_back(ref_div(model_dividend, dvs));
    @(posedge clk); #1;
    S = W'($urandom_range(0, 255));
    finish_div(hold, disturb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] dvd, dvs;
    reset        = 1'b1;
    run          = 1'b0;
    clearA_loadB = 1'b0;
    S            = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {14'd0, done, div_by_zero, Aval, Bval}, 32'd0);
    reset = 1'b0;

    load(8'd243); run_div(8'd3, 0, 1'b0);
    load(8'd200); run_div(8'd7, 20, 1'b0);
    load(8'd5);   run_div(8'd9, 1, 1'b0);
    load(8'd255); run_div(8'd1, 0, 1'b0);
    load(8'd100); run_div(8'd0, 2, 1'b0);

    // Reset partway through a division, then load and run together.
    load(8'd243);
    run = 1'b1;
    S   = 8'd3;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", {14'd0, done, div_by_zero, Aval, Bval}, 32'd0);
    reset        = 1'b0;
    clearA_loadB = 1'b1;
    run          = 1'b1;
    S            = 8'd50;
    @(posedge clk); #1;
    check("load_over_run", {15'd0, done, Aval, Bval}, {15'd0, 1'b0, 8'd0, 8'd50});
    clearA_loadB   = 1'b0;
    model_dividend = 8'd50;
    exp_q.push_back(ref_div(8'd50, 8'd50));
    @(posedge clk); #1;
    finish_div(1, 1'b0);

    load(8'd243); run_div(8'd3, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      dvd = W'($urandom_range(0, 255));
      dvs = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 255));
      load(dvd);
      run_div(dvs, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential unsigned restoring divider. It is the inverse companion of the lab's shift-add multiplier and shares its operator-facing controls: switches S, run, clearA_loadB.
- Computes dividend / divisor one quotient bit per clock.
- Exposes quotient on Bval and remainder on Aval, so the existing hex-display path in the top level drives them unchanged.

Parameters:
- WIDTH, 8, operand/result width in bits; count register is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers and returns the FSM to IDLE
- run  input  1  active-high start; latches divisor from S and begins division
- clearA_loadB  input  1  active-high; loads dividend from S into B and clears A
- S  input  WIDTH  switch operand bus
- Aval  output  WIDTH  remainder register A
- Bval  output  WIDTH  quotient/dividend register B
- done  output  1  high while in HOLD (result valid)
- div_by_zero  output  1  high while in HOLD when the latched divisor was 0

Behaviour:
- Reset (synchronous): A=0, B=0, D=0, count=0, state=IDLE, done=0, div_by_zero=0.
- Registers: A (remainder, WIDTH), B (dividend→quotient, WIDTH), D (divisor, WIDTH), count.
- Unsigned arithmetic only.
- Trial subtraction is WIDTH+1 bits: diff = {A_shifted} - {1'b0,D}; diff[WIDTH]=1 means negative.
- FSM states: IDLE, COMPUTE, HOLD.
- IDLE, clearA_loadB=1:
  - next cycle B=S, A=0; stay IDLE.
  - Takes priority over run when both are high in the same cycle; run is then honoured on a later cycle if still high.
- IDLE, run=1 (clearA_loadB=0):
  - D=S, count=0, state→COMPUTE.
  - A and B are not modified, so a dividend loaded earlier is used.
- COMPUTE, each cycle:
  - {A,B} shifted left 1 → A', B'.
  - If A' >= D: A=A'-D, B={B'[WIDTH-1:1],1}. Else: A=A', B={B'[WIDTH-1:1],0}.
  - count++.
  - After the WIDTH-th step (count reaches WIDTH), state→HOLD.
- Latency: run sampled high in IDLE at edge N → done=1 at edge N+WIDTH+1 (9 cycles for WIDTH=8).
- HOLD:
  - done=1; div_by_zero=(D==0).
  - Aval/Bval frozen.
  - Stays while run=1.
  - run=0 → IDLE on next edge; done drops.
  - Holding run high never re-triggers a division.
- Divide by zero:
  - No special datapath; the algorithm naturally yields B=all ones and A=dividend.
  - div_by_zero flags it.
- clearA_loadB in COMPUTE or HOLD: ignored.
- S changes during COMPUTE: no effect (D already latched).
- Reset mid-COMPUTE: next edge all registers zero, IDLE, done=0. No partial result survives.
- Aval/Bval are direct register outputs, no extra pipeline stage; intermediate values are visible during COMPUTE.

Decomposition:
- Package divider_pkg:
  - state enum div_state_t {IDLE, COMPUTE, HOLD}
  - default WIDTH constant
- One sub-module: divider_control. Holds the FSM and count, consumes run/clearA_loadB/count, and emits load_B, clear_A, load_D, step, done.
- Datapath (shift, trial subtract, restore mux) stays in restoring_divider.

Test Plan:
- reset; S=243, pulse clearA_loadB; S=3, pulse run → 9 cycles later done=1, Bval=0x51 (81), Aval=0x00, div_by_zero=0.
- Load 200, run with divisor 7 → Bval=28 (0x1C), Aval=4; hold run high 20 extra cycles → done stays 1, values unchanged, no restart.
- Load 5, run with divisor 9 → Bval=0, Aval=5; load 255, run with divisor 1 → Bval=255, Aval=0.
- Load 100, run with divisor 0 → Bval=0xFF, Aval=100 (0x64), div_by_zero=1; release run → done=0, div_by_zero=0 next cycle.
- Start 243/3; assert reset at COMPUTE cycle 4 → next edge Aval=Bval=0, done=0, IDLE. Then clearA_loadB and run in the same cycle with S=50 → B=50, A=0, no division starts; keeping run high next cycle starts 50/50 → Bval=1, Aval=0.
- During COMPUTE pulse clearA_loadB with S=0x77 and toggle S → result unaffected (243/3 still gives 81 rem 0).
